// File: rtl/instr_encoder_writer_if.sv
// instr_encoder_writer_if: field-bundle stream in, imem write port and status out
interface instr_encoder_writer_if #(
  parameter int INSTR_W = 16,
  parameter int OP_W    = 4,
  parameter int REG_W   = 3,
  parameter int ADDR_W  = 8
);
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic [OP_W-1:0]    in_op;
  logic [REG_W-1:0]   in_rd;
  logic [REG_W-1:0]   in_rs;
  logic [REG_W-1:0]   in_rt;
  logic [INSTR_W-1:0] in_imm;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic               done;
  logic               err;
  logic [ADDR_W:0]    prog_len;
  modport master (
    output start, in_valid, in_op, in_rd, in_rs, in_rt, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, done, err, prog_len
  );
  modport slave (
    input  start, in_valid, in_op, in_rd, in_rs, in_rt, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata, done, err, prog_len
  );
endinterface

// File: rtl/instr_encoder_writer.sv
// instr_encoder_writer: packs instruction field bundles into words and writes them to imem from address 0
module instr_encoder_writer #(
  parameter int INSTR_W = 16,
  parameter int OP_W    = 4,
  parameter int REG_W   = 3,
  parameter int ADDR_W  = 8,
  parameter logic [OP_W-1:0] OP_HALT = '1
) (
  input logic                    clk,
  input logic                    rst_n,
  instr_encoder_writer_if.slave  bus
);
  localparam int IMM_W = INSTR_W - OP_W - 2*REG_W;
  localparam int PAD_W = IMM_W - REG_W;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  typedef enum logic [2:0] {IDLE, RUN, WRITE, DONE, ERR} state_t;
  state_t             state_q, state_d;
  logic [ADDR_W:0]    ptr_q, ptr_d, ptr_inc;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] word_q, word_d, word;
  logic               halt_q, halt_d;
  logic [1:0]         cls;
  logic               accept, imm_ovf, capture;
  assign cls     = bus.in_op[OP_W-1 -: 2];
  assign accept  = bus.in_valid && state_q == RUN;
  assign ptr_inc = ptr_q + (ADDR_W+1)'(1);
  // the immediate fits only if every bit above the field repeats its sign bit
  assign imm_ovf = cls == 2'b01 &&
                   bus.in_imm[INSTR_W-1:IMM_W-1] != {(INSTR_W-IMM_W+1){bus.in_imm[IMM_W-1]}};
  assign capture = accept && !imm_ovf && !bus.start;
  assign word = cls == 2'b00 ? INSTR_W'({bus.in_op, bus.in_rd, bus.in_rs, bus.in_rt}) << PAD_W :
                cls == 2'b01 ? {bus.in_op, bus.in_rd, bus.in_rs, bus.in_imm[IMM_W-1:0]} :
                               INSTR_W'(bus.in_op) << (INSTR_W - OP_W);
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = capture ? ptr_q[ADDR_W-1:0] : addr_q;
    word_d  = capture ? word : word_q;
    halt_d  = capture ? bus.in_op == OP_HALT : halt_q;
    if (bus.start) begin
      state_d = RUN;
      ptr_d   = '0;
    end else if (state_q == WRITE) begin
      state_d = halt_q ? DONE : ptr_inc == DEPTH ? ERR : RUN;
      ptr_d   = ptr_inc;
    end else if (accept) begin
      state_d = imm_ovf ? ERR : WRITE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      halt_q  <= halt_d;
    end
  end
  assign bus.in_ready  = state_q == RUN;
  assign bus.mem_we    = state_q == WRITE;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = word_q;
  assign bus.done      = state_q == DONE;
  assign bus.err       = state_q == ERR;
  assign bus.prog_len  = ptr_q;
endmodule

// File: tb/tb_instr_encoder_writer.sv
// tb_instr_encoder_writer: random and directed bundles checked against an event-level model of the encoder
module tb_instr_encoder_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0, n_fail = 0, cyc = 0, wr0 = 0;
  int   wc0[$];
  int   wa1[$];
  instr_encoder_writer_if #(.ADDR_W(8)) b0();
  instr_encoder_writer_if #(.ADDR_W(2)) b1();
  instr_encoder_writer #(.ADDR_W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  instr_encoder_writer #(.ADDR_W(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  assign b1.start    = b0.start;
  assign b1.in_valid = b0.in_valid;
  assign b1.in_op    = b0.in_op;
  assign b1.in_rd    = b0.in_rd;
  assign b1.in_rs    = b0.in_rs;
  assign b1.in_rt    = b0.in_rt;
  assign b1.in_imm   = b0.in_imm;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference word built arithmetically from the field layout at default widths
  function automatic int enc(int op, int rd, int rs, int rt, int imm);
    int cls = op / 4;
    if (cls == 0) return op*4096 + rd*512 + rs*64 + rt*8;
    if (cls == 1) return op*4096 + rd*512 + rs*64 + (imm & 63);
    return op*4096;
  endfunction

  int       m_len = 0;
  bit       m_we = 0, m_ready = 0, m_done = 0, m_err = 0, m_halt = 0;
  bit [7:0]  m_addr = 0;
  bit [15:0] m_wdata = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_len = 0; m_we = 0; m_ready = 0; m_done = 0; m_err = 0; m_halt = 0; m_addr = 0; m_wdata = 0;
    end else if (b0.start) begin
      m_len = 0; m_we = 0; m_ready = 1; m_done = 0; m_err = 0;
    end else if (m_we) begin
      m_len++;
      m_we = 0;
      if (m_halt) m_done = 1;
      else if (m_len == 256) m_err = 1;
      else m_ready = 1;
    end else if (m_ready && b0.in_valid) begin
      m_ready = 0;
      if (b0.in_op / 4 == 1 && ($signed(b0.in_imm) > 31 || $signed(b0.in_imm) < -32)) m_err = 1;
      else begin
        m_we    = 1;
        m_addr  = 8'(m_len);
        m_wdata = 16'(enc(b0.in_op, b0.in_rd, b0.in_rs, b0.in_rt, int'($signed(b0.in_imm))));
        m_halt  = b0.in_op == 4'hF;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", b0.in_ready, m_ready);
    chk("mem_we", b0.mem_we, m_we);
    chk("mem_addr", b0.mem_addr, m_addr);
    chk("mem_wdata", b0.mem_wdata, m_wdata);
    chk("done", b0.done, m_done);
    chk("err", b0.err, m_err);
    chk("prog_len", b0.prog_len, m_len);
    if (b0.mem_we) begin
      wr0++;
      wc0.push_back(cyc);
    end
    if (b1.mem_we) wa1.push_back(int'(b1.mem_addr));
  end

  task automatic pulse_start();
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
  endtask

  task automatic send(int op, int rd, int rs, int rt, int imm, bit hold);
    int n = 0;
    b0.in_op = 4'(op); b0.in_rd = 3'(rd); b0.in_rs = 3'(rs); b0.in_rt = 3'(rt); b0.in_imm = 16'(imm);
    b0.in_valid = 1'b1;
    while (!b0.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n == 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(negedge clk);
    b0.in_valid = hold;
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_ready"}, b0.in_ready, 0);
    chk({nm, "_we"}, b0.mem_we, 0);
    chk({nm, "_addr"}, b0.mem_addr, 0);
    chk({nm, "_wdata"}, b0.mem_wdata, 0);
    chk({nm, "_done"}, b0.done, 0);
    chk({nm, "_err"}, b0.err, 0);
    chk({nm, "_len"}, b0.prog_len, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    b0.start = 0; b0.in_valid = 0; b0.in_op = 0; b0.in_rd = 0; b0.in_rs = 0; b0.in_rt = 0; b0.in_imm = 0;
    #1 rst_n = 1'b0;
    #2 chk_zero("reset");
    #9 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", b0.in_ready, 0);
    pulse_start();
    send(0, 1, 2, 3, 0, 0);
    chk("add_we", b0.mem_we, 1);
    chk("add_addr", b0.mem_addr, 0);
    chk("add_word", b0.mem_wdata, 16'h0298);
    @(negedge clk);
    chk("add_len", b0.prog_len, 1);
    pulse_start();
    send(4, 1, 0, 0, -32, 0);
    chk("addi_word", b0.mem_wdata, 16'h4220);
    send(15, 0, 0, 0, 0, 0);
    chk("halt_addr", b0.mem_addr, 1);
    chk("halt_word", b0.mem_wdata, 16'hF000);
    @(negedge clk);
    chk("halt_done", b0.done, 1);
    chk("halt_len", b0.prog_len, 2);
    pulse_start();
    w = wr0;
    send(4, 1, 0, 0, 32, 0);
    @(negedge clk);
    chk("ovf_err", b0.err, 1);
    chk("ovf_len", b0.prog_len, 0);
    chk("ovf_nowrite", wr0, w);
    pulse_start();
    chk("start_clears_err", b0.err, 0);
    wa1.delete();
    for (int i = 0; i < 4; i++) send(0, i, i, i, 0, 0);
    @(negedge clk);
    chk("full_err", b1.err, 1);
    chk("full_len", b1.prog_len, 4);
    chk("full_writes", wa1.size(), 4);
    for (int i = 0; i < 4 && i < wa1.size(); i++) chk("full_addr", wa1[i], i);
    pulse_start();
    wc0.delete();
    send(0, 1, 1, 1, 0, 1);
    send(4, 2, 2, 0, 5, 1);
    send(8, 3, 3, 3, 0, 0);
    repeat (3) @(negedge clk);
    chk("b2b_writes", wc0.size(), 3);
    if (wc0.size() == 3) begin
      chk("b2b_gap1", wc0[1] - wc0[0], 2);
      chk("b2b_gap2", wc0[2] - wc0[1], 2);
    end
    for (int i = 0; i < 300; i++) begin
      if (m_we) @(negedge clk);
      if (!m_ready) pulse_start();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           int'($urandom_range(0, 80)) - 40, 0);
      if ($urandom_range(0, 7) == 0) pulse_start();
    end
    if (m_we) @(negedge clk);
    pulse_start();
    send(0, 7, 7, 7, 0, 0);
    @(negedge clk);
    send(0, 5, 6, 7, 0, 0);
    chk("pre_rst_we", b0.mem_we, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("midwrite_rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", b0.in_ready, 0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
